keypad_input: RTL and testbench

Scans a 4x4 matrix keypad, debounces it, and turns key presses into an accumulated decimal number for the CPU I/O path. It is the input-side counterpart of the multiplexed 7-segment display driver. It drives keypad rows one at a time and samples the columns. Its 24-bit value output is sized to feed the display's 24-bit data input and the CPU's MMIO read port directly.

---
 rtl/keypad_input_pkg.sv | 47 ++++
 rtl/keypad_input_if.sv | 21 ++
 rtl/keypad_input_key_debouncer.sv | 73 +++++++
 rtl/keypad_input.sv | 112 +++++++++++
 tb/tb_keypad_input.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_input_pkg.sv
// Shared key codes, the "no key" encoding, debouncer states and the
// position-to-code map for the 4x4 keypad.
package keypad_input_pkg;

  localparam int MAX_DIGITS_DEF = 7;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Candidate per scan round: bit 4 set means no single key was seen.
  typedef logic [4:0] cand_t;
  localparam cand_t KEY_NONE = 5'h10;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_RELEASE_WAIT
  } db_state_t;

  // Position is row*4 + col.
  function automatic logic [3:0] pos_to_code(input logic [3:0] pos);
    case (pos)
      4'd0:    return 4'd1;
      4'd1:    return 4'd2;
      4'd2:    return 4'd3;
      4'd3:    return KEY_A;
      4'd4:    return 4'd4;
      4'd5:    return 4'd5;
      4'd6:    return 4'd6;
      4'd7:    return KEY_B;
      4'd8:    return 4'd7;
      4'd9:    return 4'd8;
      4'd10:   return 4'd9;
      4'd11:   return KEY_C;
      4'd12:   return KEY_STAR;
      4'd13:   return 4'd0;
      4'd14:   return KEY_HASH;
      default: return KEY_D;
    endcase
  endfunction

endpackage

// File: rtl/keypad_input_if.sv
// Keypad pins plus the decoded-number outputs toward CPU / display.
interface keypad_input_if;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [23:0] value;
  logic [3:0]  digit_count;
  logic        entered;
  logic [23:0] entered_value;

  modport master (
    input  col_in,
    output row_out, key_valid, key_code, value, digit_count, entered, entered_value
  );

  modport slave (
    output col_in,
    input  row_out, key_valid, key_code, value, digit_count, entered, entered_value
  );
endinterface

// File: rtl/keypad_input_key_debouncer.sv
// Round-level debouncer: a key is accepted after ROUNDS identical rounds and
// released after ROUNDS empty rounds. press is a strobe on the accepting
// round-done cycle so the accumulator registers it one cycle later.
module key_debouncer
  import keypad_input_pkg::*;
#(
  parameter int ROUNDS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       round_done,
  input  cand_t      cand,
  output logic       press,
  output logic [3:0] press_key
);

  localparam int CW = $clog2(ROUNDS + 1);

  db_state_t     state;
  logic [CW-1:0] cnt;
  logic [3:0]    key;
  logic          none, same, last_round;

  assign none       = cand[4];
  assign same       = !none && (cand[3:0] == key);
  assign last_round = (cnt == CW'(ROUNDS - 1));
  assign press      = round_done && (state == DB_PRESS_WAIT) && same && last_round;
  assign press_key  = key;

  // Debounce FSM, advanced once per completed scan round.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DB_IDLE;
      cnt   <= '0;
      key   <= '0;
    end else if (round_done) begin
      case (state)
        DB_IDLE: if (!none) begin
          state <= DB_PRESS_WAIT;
          key   <= cand[3:0];
          cnt   <= CW'(1);
        end
        DB_PRESS_WAIT: begin
          if (!same) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else if (last_round) begin
            state <= DB_HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DB_HELD: if (none) begin
          state <= DB_RELEASE_WAIT;
          cnt   <= CW'(1);
        end
        default: begin
          if (!none) begin
            state <= DB_HELD;
            cnt   <= '0;
          end else if (last_round) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_input.sv
// 4x4 keypad scanner: prescaled row scan, per-round decode, debouncer and a
// decimal accumulator with backspace, clear and enter.
module keypad_input
  import keypad_input_pkg::*;
#(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_ROUNDS = 5,
  parameter int MAX_DIGITS      = MAX_DIGITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  keypad_input_if.master  kp
);

  localparam int DIV = CLK_FREQ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick, round_done;
  logic [1:0]    row_idx;
  logic [15:0]   round_map, map_next;
  cand_t         cand;
  logic          press;
  logic [3:0]    press_key;

  assign tick       = (presc == PW'(DIV - 1));
  assign round_done = tick && (row_idx == 2'd3);
  assign kp.row_out = ~(4'b0001 << row_idx);

  // Round map with the currently driven row's columns merged in.
  always_comb begin
    map_next = round_map;
    map_next[{row_idx, 2'b00} +: 4] = ~kp.col_in;
  end

  // Exactly one key down gives a candidate; anything else is NONE.
  always_comb begin
    cand = KEY_NONE;
    if (map_next != '0 && (map_next & (map_next - 16'd1)) == '0) begin
      for (int i = 0; i < 16; i++)
        if (map_next[i]) cand = {1'b0, pos_to_code(4'(i))};
    end
  end

  // Prescaler, row advance and column sampling on each tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      row_idx   <= '0;
      round_map <= '0;
    end else if (tick) begin
      presc     <= '0;
      row_idx   <= row_idx + 2'd1;
      round_map <= map_next;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  key_debouncer #(.ROUNDS(DEBOUNCE_ROUNDS)) u_db (
    .clk        (clk),
    .rst        (rst),
    .round_done (round_done),
    .cand       (cand),
    .press      (press),
    .press_key  (press_key)
  );

  // Accumulator: applies each accepted key and raises the one-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      kp.key_valid     <= 1'b0;
      kp.key_code      <= '0;
      kp.value         <= '0;
      kp.digit_count   <= '0;
      kp.entered       <= 1'b0;
      kp.entered_value <= '0;
    end else begin
      kp.key_valid <= press;
      kp.entered   <= 1'b0;
      if (press) begin
        kp.key_code <= press_key;
        if (press_key <= 4'd9) begin
          if (kp.digit_count < 4'(MAX_DIGITS)) begin
            kp.value       <= (kp.value << 3) + (kp.value << 1) + {20'd0, press_key};
            kp.digit_count <= kp.digit_count + 4'd1;
          end
        end else begin
          case (press_key)
            KEY_A: if (kp.digit_count != '0) begin
              kp.value       <= kp.value / 24'd10;
              kp.digit_count <= kp.digit_count - 4'd1;
            end
            KEY_STAR: begin
              kp.value       <= '0;
              kp.digit_count <= '0;
            end
            KEY_HASH: begin
              kp.entered       <= 1'b1;
              kp.entered_value <= kp.value;
              kp.value         <= '0;
              kp.digit_count   <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_input.sv
// Bench for keypad_input: a mechanical keypad model drives col_in from a
// pressed-key mask, and a round-level behavioural model predicts every output.
module tb_keypad_input;

  localparam int ROUNDS = 5;
  localparam int MAXD   = 7;
  localparam int DIV    = 10;
  localparam int RCYC   = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = '0;
  bit          chk_en = 0;
  int          n_cmp = 0, n_err = 0;
  int          kv_seen = 0, ent_seen = 0;

  keypad_input_if kp();

  keypad_input #(
    .CLK_FREQ(1000), .SCAN_HZ(100), .DEBOUNCE_ROUNDS(ROUNDS), .MAX_DIGITS(MAXD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    kp.col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kp.row_out[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) kp.col_in[c] = 1'b0;
  end

  // ---------------- behavioural model ----------------
  int code_of [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int cyc, ticks, run, rel, last, mval, mcnt, mev, mcode;
  bit held, mkv, ment;
  logic [3:0]  mrow = 4'b1110;
  logic [15:0] mmap;

  always @(posedge clk) begin
    int r, cand, ones;
    mkv  = 0;
    ment = 0;
    if (rst) begin
      cyc = 0; ticks = 0; run = 0; rel = 0; last = 0; held = 0;
      mval = 0; mcnt = 0; mev = 0; mcode = 0; mmap = '0;
    end else begin
      if (cyc % DIV == DIV - 1) begin
        r = ticks % 4;
        for (int c = 0; c < 4; c++) mmap[r*4+c] = pressed[r*4+c];
        ticks++;
        if (r == 3) begin
          ones = 0;
          cand = -1;
          for (int i = 0; i < 16; i++)
            if (mmap[i]) begin ones++; cand = code_of[i]; end
          if (ones != 1) cand = -1;
          if (!held) begin
            if (cand < 0) run = 0;
            else if (run == 0) begin run = 1; last = cand; end
            else if (cand == last) run++;
            else run = 0;
            if (run == ROUNDS) begin
              held = 1; run = 0; rel = 0;
              mkv = 1; mcode = last;
              if (last <= 9) begin
                if (mcnt < MAXD) begin mval = mval * 10 + last; mcnt++; end
              end else if (last == 10) begin
                if (mcnt > 0) begin mval = mval / 10; mcnt--; end
              end else if (last == 14) begin
                mval = 0; mcnt = 0;
              end else if (last == 15) begin
                ment = 1; mev = mval; mval = 0; mcnt = 0;
              end
            end
          end else begin
            if (cand < 0) rel++; else rel = 0;
            if (rel == ROUNDS) begin held = 0; rel = 0; end
          end
        end
      end
      cyc++;
    end
    mrow = 4'hF;
    mrow[ticks % 4] = 1'b0;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (kp.row_out !== mrow || kp.key_valid !== mkv || kp.key_code !== 4'(mcode) ||
          kp.value !== 24'(mval) || kp.digit_count !== 4'(mcnt) ||
          kp.entered !== ment || kp.entered_value !== 24'(mev)) begin
        n_err++;
        $display("FAIL outputs t=%0t row_out=%b exp %b key_valid=%b exp %b key_code=%0d exp %0d value=%0d exp %0d digit_count=%0d exp %0d entered=%b exp %b entered_value=%0d exp %0d",
                 $time, kp.row_out, mrow, kp.key_valid, mkv, kp.key_code, mcode,
                 kp.value, mval, kp.digit_count, mcnt, kp.entered, ment, kp.entered_value, mev);
      end
      if (kp.key_valid === 1'b1) kv_seen++;
      if (kp.entered === 1'b1) ent_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic hold_cyc(input logic [15:0] m, input int n);
    pressed = m;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [15:0] m, input int rounds);
    hold_cyc(m, rounds * RCYC);
  endtask

  task automatic tap(input int pos);
    hold(16'(1 << pos), 6);
    hold('0, 7);
  endtask

  initial begin
    int base, ebase, sel, p1, p2;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    chk("reset_row_out", int'(kp.row_out), 4'b1110);
    chk("reset_value", int'(kp.value), 0);
    chk("reset_count", int'(kp.digit_count), 0);
    chk("reset_pulses", int'(kp.key_valid) + int'(kp.entered), 0);
    rst = 0;

    repeat (5) @(negedge clk);
    chk("walk_row0", int'(kp.row_out), 4'b1110);
    repeat (10) @(negedge clk);
    chk("walk_row1", int'(kp.row_out), 4'b1101);
    repeat (10) @(negedge clk);
    chk("walk_row2", int'(kp.row_out), 4'b1011);
    repeat (10) @(negedge clk);
    chk("walk_row3", int'(kp.row_out), 4'b0111);

    // clean press of 5, then a long hold
    base = kv_seen;
    hold(16'(1 << 5), 6);
    chk("clean_pulses", kv_seen - base, 1);
    chk("clean_code", int'(kp.key_code), 5);
    chk("clean_value", int'(kp.value), 5);
    chk("clean_count", int'(kp.digit_count), 1);
    hold(16'(1 << 5), 50);
    chk("held_no_repeat", kv_seen - base, 1);
    hold('0, 7);
    tap(12);
    chk("star_clear", int'(kp.value), 0);

    // bouncing 7
    base = kv_seen;
    repeat (2) begin hold(16'(1 << 8), 1); hold('0, 1); end
    hold(16'(1 << 8), 7);
    hold('0, 7);
    chk("bounce_pulses", kv_seen - base, 1);
    chk("bounce_value", int'(kp.value), 7);
    tap(12);

    // 1 2 3 A then #
    tap(0); tap(1); tap(2); tap(3);
    chk("edit_value", int'(kp.value), 12);
    chk("edit_count", int'(kp.digit_count), 2);
    ebase = ent_seen;
    tap(14);
    chk("enter_pulses", ent_seen - ebase, 1);
    chk("enter_latched", int'(kp.entered_value), 12);
    chk("enter_value_clr", int'(kp.value), 0);
    chk("enter_count_clr", int'(kp.digit_count), 0);

    // digit limit
    base = kv_seen;
    repeat (8) tap(10);
    chk("limit_pulses", kv_seen - base, 8);
    chk("limit_value", int'(kp.value), 9_999_999);
    chk("limit_count", int'(kp.digit_count), 7);
    tap(12);
    chk("limit_clear", int'(kp.value), 0);

    // two keys together
    base = kv_seen;
    hold(16'h0003, 10);
    hold('0, 7);
    chk("dual_no_event", kv_seen - base, 0);

    // reset during PRESS_WAIT, key still held afterwards
    tap(4);
    chk("pre_reset_value", int'(kp.value), 4);
    base = kv_seen;
    hold(16'(1 << 6), 3);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_no_event", kv_seen - base, 0);
    chk("rst_value", int'(kp.value), 0);
    chk("rst_entered_value", int'(kp.entered_value), 0);
    chk("rst_row_out", int'(kp.row_out), 4'b1110);
    rst = 0;
    hold(16'(1 << 6), 7);
    chk("after_rst_press", kv_seen - base, 1);
    chk("after_rst_value", int'(kp.value), 6);
    hold('0, 7);

    // randomized presses, switches, combos and releases
    repeat (40) begin
      sel = $urandom_range(0, 9);
      p1  = $urandom_range(0, 15);
      p2  = $urandom_range(0, 15);
      if (sel < 2) hold_cyc(16'((1 << p1) | (1 << p2)), $urandom_range(20, 320));
      else         hold_cyc(16'(1 << p1), $urandom_range(20, 320));
      if ($urandom_range(0, 3) != 0) hold_cyc('0, $urandom_range(20, 320));
    end
    hold('0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
